// File: rtl/matrix_mac_engine.sv
// Sequential M x K by K x N signed matrix multiply, one MAC per cycle, with
// overwrite / saturating accumulate / saturating subtract into a persistent C.
module matrix_mac_engine #(
  parameter int word_size     = 8,
  parameter int Amatrixrownum = 2,
  parameter int Amatrixcolnum = 2,
  parameter int Bmatrixcolnum = 2,
  parameter int acc_w         = 2 * word_size + $clog2(Amatrixcolnum)
) (
  input  logic                                                clk,
  input  logic                                                resetn,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0]    A,
  input  logic [Amatrixcolnum*Bmatrixcolnum*word_size-1:0]    B,
  input  logic [1:0]                                          op,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [Amatrixrownum*Bmatrixcolnum*acc_w-1:0]        C,
  output logic                                                busy
);

  localparam int M  = Amatrixrownum;
  localparam int K  = Amatrixcolnum;
  localparam int N  = Bmatrixcolnum;
  localparam int W  = word_size;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);

  localparam logic signed [acc_w-1:0] SAT_MAX = {1'b0, {(acc_w-1){1'b1}}};
  localparam logic signed [acc_w-1:0] SAT_MIN = {1'b1, {(acc_w-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MAC = 2'b01, OP_MSUB = 2'b10, OP_CLR = 2'b11} op_e;

  state_e                          state_q;
  op_e                             op_q;
  logic [M*K*W-1:0]                a_q;
  logic [K*N*W-1:0]                b_q;
  logic [IW-1:0]                   i_q;
  logic [JW-1:0]                   j_q;
  logic [KW-1:0]                   k_q;
  logic signed [acc_w-1:0]         sum_q;
  logic [M*N*acc_w-1:0]            c_q;

  int                              a_idx, b_idx, c_idx;
  logic signed [W-1:0]             a_el, b_el;
  logic signed [2*W-1:0]           prod;
  logic signed [acc_w-1:0]         sum_d;
  logic signed [acc_w-1:0]         c_old;
  logic signed [acc_w:0]           wide_d;
  logic signed [acc_w-1:0]         elem_d;

  // NOTE: every always_comb output gets a value on every path before any
  // conditional logic, otherwise synthesis infers a latch.
  always_comb begin
    a_idx  = int'(i_q) * K + int'(k_q);
    b_idx  = int'(k_q) * N + int'(j_q);
    c_idx  = int'(i_q) * N + int'(j_q);
    a_el   = a_q[(M*K-1-a_idx)*W +: W];
    b_el   = b_q[(K*N-1-b_idx)*W +: W];
    prod   = a_el * b_el;
    sum_d  = sum_q + acc_w'(prod);
    c_old  = c_q[(M*N-1-c_idx)*acc_w +: acc_w];
    // One guard bit lets overflow show up as a disagreement of the top two bits.
    if (op_q == OP_MSUB) wide_d = (acc_w+1)'(c_old) - (acc_w+1)'(sum_d);
    else                 wide_d = (acc_w+1)'(c_old) + (acc_w+1)'(sum_d);
    if (op_q == OP_MUL)                       elem_d = sum_d;
    else if (wide_d[acc_w] != wide_d[acc_w-1]) elem_d = wide_d[acc_w] ? SAT_MIN : SAT_MAX;
    else                                      elem_d = wide_d[acc_w-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: C is reset because reset must leave a defined all-zero result,
  // unlike plain storage arrays that normally need no reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      c_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= op_e'(op);
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            sum_q <= '0;
            if (op_e'(op) == OP_CLR) begin
              c_q     <= '0;
              state_q <= DONE;
            end else begin
              state_q <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          if (k_q == K_LAST) begin
            c_q[(M*N-1-c_idx)*acc_w +: acc_w] <= elem_d;
            sum_q <= '0;
            k_q   <= '0;
            if (j_q == J_LAST) begin
              j_q <= '0;
              if (i_q == I_LAST) begin
                i_q     <= '0;
                state_q <= DONE;
              end else begin
                i_q <= i_q + IW'(1);
              end
            end else begin
              j_q <= j_q + JW'(1);
            end
          end else begin
            sum_q <= sum_d;
            k_q   <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == COMPUTE);
  assign out_valid = (state_q == DONE);
  assign C         = c_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Self-checking bench: 2x2x2 engine against a matrix-level model, plus a
// 3x2x1 instance for non-square shapes.
module tb_matrix_mac_engine;

  localparam int W   = 8;
  localparam int ACC = 17;
  localparam int MIN_V = -65536;
  localparam int MAX_V = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic        iv0, ir0, ov0, or0, busy0;
  logic [1:0]  op0;
  logic [31:0] a0, b0;
  logic [67:0] c0;

  logic        iv1, ir1, ov1, or1, busy1;
  logic [1:0]  op1;
  logic [47:0] a1;
  logic [15:0] b1;
  logic [50:0] c1;

  matrix_mac_engine #(.word_size(8), .Amatrixrownum(2), .Amatrixcolnum(2), .Bmatrixcolnum(2)) dut0 (
    .clk(clk), .resetn(resetn), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0), .op(op0),
    .out_valid(ov0), .out_ready(or0), .C(c0), .busy(busy0));

  matrix_mac_engine #(.word_size(8), .Amatrixrownum(3), .Amatrixcolnum(2), .Bmatrixcolnum(1)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1), .op(op1),
    .out_valid(ov1), .out_ready(or1), .C(c1), .busy(busy1));

  int n_checks = 0;
  int n_fail   = 0;
  longint mc0[4];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > MAX_V) return MAX_V;
    if (v < MIN_V) return MIN_V;
    return v;
  endfunction

  // Reference: C_new = f(C_old, A*B) computed as whole matrices.
  function automatic void model0(input logic [1:0] op, input int a[4], input int b[4]);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        longint s = 0;
        for (int k = 0; k < 2; k++) s += longint'(a[i*2+k]) * longint'(b[k*2+j]);
        case (op)
          2'b00: mc0[i*2+j] = s;
          2'b01: mc0[i*2+j] = sat(mc0[i*2+j] + s);
          2'b10: mc0[i*2+j] = sat(mc0[i*2+j] - s);
          default: mc0[i*2+j] = 0;
        endcase
      end
  endfunction

  function automatic logic [127:0] pack0();
    logic [127:0] r = '0;
    for (int e = 0; e < 4; e++) r[(3-e)*ACC +: ACC] = ACC'(mc0[e]);
    return r;
  endfunction

  task automatic run0(input logic [1:0] op, input int a[4], input int b[4], input int hold, input string tag);
    logic [31:0]  af, bf;
    logic [127:0] exp_c;
    int cyc, bc, exp_lat, exp_busy;
    for (int e = 0; e < 4; e++) begin
      af[(3-e)*W +: W] = W'(a[e]);
      bf[(3-e)*W +: W] = W'(b[e]);
    end
    check({tag, ".in_ready"}, 128'(ir0), 128'(1));
    iv0 = 1'b1; a0 = af; b0 = bf; op0 = op;
    @(posedge clk); #1;
    iv0 = 1'b0; a0 = $urandom; b0 = $urandom; op0 = 2'($urandom);
    model0(op, a, b);
    exp_c    = pack0();
    exp_lat  = (op == 2'b11) ? 1 : 9;
    exp_busy = (op == 2'b11) ? 0 : 8;
    cyc = 1; bc = 0;
    while (!ov0 && cyc < 64) begin
      if (busy0) bc++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 128'(cyc), 128'(exp_lat));
    check({tag, ".busy_cycles"}, 128'(bc), 128'(exp_busy));
    check({tag, ".C"}, 128'(c0), exp_c);
    for (int h = 0; h < hold; h++) begin
      iv0 = (h == 1);
      @(posedge clk); #1;
      iv0 = 1'b0;
      check({tag, ".hold_valid"}, 128'(ov0), 128'(1));
      check({tag, ".hold_C"}, 128'(c0), exp_c);
      check({tag, ".hold_in_ready"}, 128'(ir0), 128'(0));
    end
    or0 = 1'b1;
    @(posedge clk); #1;
    or0 = 1'b0;
    check({tag, ".released_valid"}, 128'(ov0), 128'(0));
    check({tag, ".released_in_ready"}, 128'(ir0), 128'(1));
  endtask

  task automatic run1(input int a[6], input int b[2], input string tag);
    logic [127:0] exp_c = '0;
    int cyc;
    for (int e = 0; e < 6; e++) a1[(5-e)*W +: W] = W'(a[e]);
    for (int e = 0; e < 2; e++) b1[(1-e)*W +: W] = W'(b[e]);
    for (int i = 0; i < 3; i++)
      exp_c[(2-i)*ACC +: ACC] = ACC'(a[2*i] * b[0] + a[2*i+1] * b[1]);
    iv1 = 1'b1; op1 = 2'b00;
    @(posedge clk); #1;
    iv1 = 1'b0; a1 = {$urandom, $urandom}; b1 = 16'($urandom);
    cyc = 1;
    while (!ov1 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 128'(cyc), 128'(7));
    check({tag, ".C"}, 128'(c1), exp_c);
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    check({tag, ".in_ready"}, 128'(ir1), 128'(1));
  endtask

  initial begin
    int ta[4], tb[4], na[6], nb[2];
    resetn = 1'b0;
    iv0 = 0; or0 = 0; op0 = 0; a0 = 0; b0 = 0;
    iv1 = 0; or1 = 0; op1 = 0; a1 = 0; b1 = 0;
    for (int e = 0; e < 4; e++) mc0[e] = 0;
    #12;
    check("reset.in_ready",  128'(ir0), 128'(1));
    check("reset.out_valid", 128'(ov0), 128'(0));
    check("reset.busy",      128'(busy0), 128'(0));
    check("reset.C",         128'(c0), 128'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    ta = '{1, 2, 3, 0}; tb = '{5, 6, 7, 8};
    run0(2'b00, ta, tb, 0, "mul");
    run0(2'b01, ta, tb, 0, "mac");
    run0(2'b10, ta, tb, 5, "msub_backpressure");

    ta = '{-128, -128, -128, -128}; tb = ta;
    run0(2'b11, ta, tb, 0, "clr");
    run0(2'b01, ta, tb, 0, "sat_mac1");
    run0(2'b01, ta, tb, 0, "sat_mac2");
    run0(2'b11, ta, tb, 0, "clr2");
    run0(2'b10, ta, tb, 0, "sat_msub1");
    run0(2'b10, ta, tb, 0, "sat_msub2");
    run0(2'b10, ta, tb, 0, "sat_msub3");

    // Abort a MUL on its 4th COMPUTE cycle.
    ta = '{1, 2, 3, 0}; tb = '{5, 6, 7, 8};
    for (int e = 0; e < 4; e++) begin
      a0[(3-e)*W +: W] = W'(ta[e]);
      b0[(3-e)*W +: W] = W'(tb[e]);
    end
    iv0 = 1'b1; op0 = 2'b00;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midreset.busy_before", 128'(busy0), 128'(1));
    resetn = 1'b0;
    #1;
    for (int e = 0; e < 4; e++) mc0[e] = 0;
    check("midreset.busy",      128'(busy0), 128'(0));
    check("midreset.out_valid", 128'(ov0), 128'(0));
    check("midreset.C",         128'(c0), 128'(0));
    check("midreset.in_ready",  128'(ir0), 128'(1));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run0(2'b00, ta, tb, 0, "mul_after_reset");

    for (int t = 0; t < 10; t++) begin
      for (int e = 0; e < 4; e++) begin
        ta[e] = int'($urandom_range(255)) - 128;
        tb[e] = int'($urandom_range(255)) - 128;
      end
      run0(2'($urandom_range(3)), ta, tb, int'($urandom_range(2)), $sformatf("rand%0d", t));
    end

    na = '{1, -2, 3, 4, -5, 6}; nb = '{7, 8};
    run1(na, nb, "nonsquare");
    for (int t = 0; t < 3; t++) begin
      for (int e = 0; e < 6; e++) na[e] = int'($urandom_range(255)) - 128;
      for (int e = 0; e < 2; e++) nb[e] = int'($urandom_range(255)) - 128;
      run1(na, nb, $sformatf("nonsquare_rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
